// File: rtl/mt_maint_pkg.sv
// Shared types for the MT maintenance wraparound sequencer.
// FSM states, maintenance opcodes and the 9-bit formatter character.
package mt_maint_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    GAP,
    READ,
    DONE
  } mt_state_e;

  typedef logic [8:0] mt_char_t;

  localparam logic [3:0] mtMROP_NOP  = 4'd0;
  localparam logic [3:0] mtMROP_WRP1 = 4'd1;
  localparam logic [3:0] mtMROP_WRP2 = 4'd2;
  localparam logic [3:0] mtMROP_WRP3 = 4'd3;

  function automatic logic is_wrp(input logic [3:0] mop);
    return (mop == mtMROP_WRP1) ||
           (mop == mtMROP_WRP2) ||
           (mop == mtMROP_WRP3);
  endfunction

endpackage

// File: rtl/mt_lb_fifo.sv
// Loopback character FIFO, DEPTH x 9, with synchronous flush.
// Head is presented combinationally on dout_o.
module mt_lb_fifo
  import mt_maint_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     flush_i,
  input  logic     push_i,
  input  mt_char_t din_i,
  input  logic     pop_i,
  output mt_char_t dout_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int AW = $clog2(DEPTH);

  mt_char_t    mem_q [DEPTH];
  logic [AW:0] wp_q;
  logic [AW:0] rp_q;

  assign empty_o = (wp_q == rp_q);
  assign full_o  = (wp_q[AW] != rp_q[AW]) &&
                   (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign dout_o  = mem_q[rp_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (push_i && !full_o)
        wp_q <= wp_q + {{AW{1'b0}}, 1'b1};
      if (pop_i && !empty_o)
        rp_q <= rp_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !full_o && !flush_i)
      mem_q[wp_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/mt_maint_loopback_seq.sv
// MT maintenance-mode wraparound sequencer: record write,
// inter-record gap, then replay of the record to the read path.
module mt_maint_loopback_seq
  import mt_maint_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int GAP_STEPS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mtMM,
  input  logic [3:0]  mtMOP,
  input  logic        mtMC,
  input  logic        mtBPICLK,
  input  logic        mtGO,
  input  logic        wrVALID,
  input  logic [8:0]  wrDATA,
  output logic        wrREADY,
  output logic        rdVALID,
  output logic [8:0]  rdDATA,
  input  logic        rdREADY,
  output logic [8:0]  mtMDF,
  output logic        mtBUSY,
  output logic        mtEOR,
  output logic        mtOVR,
  output logic [15:0] mtFRMCNT
);

  localparam int GW = $clog2(GAP_STEPS + 1);

  mt_state_e   state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic        mc_q, mc2_q, bpi_q, bpi2_q, go_q;
  logic        busy_q, eor_q, eor_d;
  logic        rdv_q, rdv_d, ovr_q, ovr_d;
  mt_char_t    rdd_q, rdd_d, mdf_q, mdf_d;
  logic [15:0] cnt_q, cnt_d;
  logic        step, go_rise;
  logic        push, pop, flush, wr_rdy;
  mt_char_t    head;
  logic        full, empty;

  // Steps come from the registered clock levels, so they land one cycle late.
  assign step = mtMM && (is_wrp(mtMOP) ? (mc_q ^ mc2_q)
                                       : (bpi_q & ~bpi2_q));
  assign go_rise = mtGO & ~go_q;

  mt_lb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .push_i  (push),
    .din_i   (wrDATA),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    rdv_d   = rdv_q;
    rdd_d   = rdd_q;
    mdf_d   = mdf_q;
    ovr_d   = ovr_q;
    cnt_d   = cnt_q;
    eor_d   = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;
    wr_rdy  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mtMM && go_rise) begin
          state_d = WRITE;
          cnt_d   = '0;
          ovr_d   = 1'b0;
          flush   = 1'b1;
        end
      end
      WRITE: begin
        if (step) begin
          if (wrVALID && !full) begin
            wr_rdy = 1'b1;
            push   = 1'b1;
            mdf_d  = wrDATA;
            cnt_d  = cnt_q + 16'd1;
          end else if (wrVALID) begin
            ovr_d = 1'b1;
          end else begin
            state_d = GAP;
            gap_d   = GW'(GAP_STEPS);
          end
        end
      end
      GAP: begin
        if (step) begin
          gap_d = gap_q - GW'(1);
          if (gap_q == GW'(1))
            state_d = READ;
        end
      end
      READ: begin
        if (rdv_q && rdREADY) begin
          pop   = 1'b1;
          rdv_d = 1'b0;
        end else if (step) begin
          if (rdv_q) begin
            ovr_d = 1'b1;
          end else if (!empty) begin
            rdv_d = 1'b1;
            rdd_d = head;
            mdf_d = head;
          end else begin
            eor_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Leaving maintenance mode aborts the record silently.
    if (state_q != IDLE && !mtMM) begin
      state_d = IDLE;
      flush   = 1'b1;
      rdv_d   = 1'b0;
      eor_d   = 1'b0;
      push    = 1'b0;
      pop     = 1'b0;
      wr_rdy  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gap_q   <= GW'(GAP_STEPS);
      mc_q    <= 1'b0;
      mc2_q   <= 1'b0;
      bpi_q   <= 1'b0;
      bpi2_q  <= 1'b0;
      go_q    <= 1'b0;
      busy_q  <= 1'b0;
      eor_q   <= 1'b0;
      rdv_q   <= 1'b0;
      rdd_q   <= '0;
      mdf_q   <= '0;
      ovr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      mc_q    <= mtMC;
      mc2_q   <= mc_q;
      bpi_q   <= mtBPICLK;
      bpi2_q  <= bpi_q;
      go_q    <= mtGO;
      busy_q  <= (state_d != IDLE);
      eor_q   <= eor_d;
      rdv_q   <= rdv_d;
      rdd_q   <= rdd_d;
      mdf_q   <= mdf_d;
      ovr_q   <= ovr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wrREADY  = wr_rdy;
  assign rdVALID  = rdv_q;
  assign rdDATA   = rdd_q;
  assign mtMDF    = mdf_q;
  assign mtBUSY   = busy_q;
  assign mtEOR    = eor_q;
  assign mtOVR    = ovr_q;
  assign mtFRMCNT = cnt_q;

endmodule

// File: tb/tb_mt_maint_loopback_seq.sv
// Directed bench for the MT maintenance wraparound sequencer.
// Expected values are hand-derived per scenario.
module tb_mt_maint_loopback_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        mtMM;
  logic [3:0]  mtMOP;
  logic        mtMC;
  logic        mtBPICLK;
  logic        mtGO;
  logic        wrVALID;
  logic [8:0]  wrDATA;
  logic        wrREADY;
  logic        rdVALID;
  logic [8:0]  rdDATA;
  logic        rdREADY;
  logic [8:0]  mtMDF;
  logic        mtBUSY;
  logic        mtEOR;
  logic        mtOVR;
  logic [15:0] mtFRMCNT;

  int n_chk = 0;
  int n_err = 0;
  int rdy_cnt = 0;
  int eor_cnt = 0;
  bit wrp_mode = 1'b1;
  logic [8:0] exp_chr [3];

  mt_maint_loopback_seq #(.DEPTH(16), .GAP_STEPS(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .mtMM     (mtMM),
    .mtMOP    (mtMOP),
    .mtMC     (mtMC),
    .mtBPICLK (mtBPICLK),
    .mtGO     (mtGO),
    .wrVALID  (wrVALID),
    .wrDATA   (wrDATA),
    .wrREADY  (wrREADY),
    .rdVALID  (rdVALID),
    .rdDATA   (rdDATA),
    .rdREADY  (rdREADY),
    .mtMDF    (mtMDF),
    .mtBUSY   (mtBUSY),
    .mtEOR    (mtEOR),
    .mtOVR    (mtOVR),
    .mtFRMCNT (mtFRMCNT)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wrREADY) rdy_cnt++;
    if (mtEOR) eor_cnt++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mc_step;
    @(negedge clk);
    mtMC = ~mtMC;
    tick(2);
  endtask

  task automatic bpi_step;
    @(negedge clk);
    mtBPICLK = 1'b1;
    tick(2);
    @(negedge clk);
    mtBPICLK = 1'b0;
    tick(2);
  endtask

  task automatic step;
    if (wrp_mode) mc_step();
    else bpi_step();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic go_pulse;
    @(negedge clk);
    mtGO = 1'b1;
    tick(1);
    @(negedge clk);
    mtGO = 1'b0;
    tick(1);
  endtask

  task automatic handshake;
    @(negedge clk);
    rdREADY = 1'b1;
    tick(1);
    @(negedge clk);
    rdREADY = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mtMM = 1'b0; mtMOP = 4'd1; mtMC = 1'b0;
    mtBPICLK = 1'b0; mtGO = 1'b0; wrVALID = 1'b0;
    wrDATA = '0; rdREADY = 1'b0;
    tick(3);
    check("rst_busy", 32'(mtBUSY), 0);
    check("rst_outs", {rdVALID, wrREADY, mtEOR, mtOVR, rdDATA, mtMDF},
          0);
    check("rst_cnt", 32'(mtFRMCNT), 0);
    @(negedge clk);
    rst = 1'b0;
    mtMM = 1'b1;

    // WRP1 record of three characters, then replay
    exp_chr[0] = 9'h155; exp_chr[1] = 9'h0AA; exp_chr[2] = 9'h1FF;
    go_pulse();
    check("go_busy", 32'(mtBUSY), 1);
    wrVALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wrDATA = exp_chr[i];
      mc_step();
    end
    wrVALID = 1'b0;
    mc_step();
    check("w1_rdy", 32'(rdy_cnt), 3);
    check("w1_cnt", 32'(mtFRMCNT), 3);
    check("w1_mdf", 32'(mtMDF), 32'h1FF);
    steps(7);
    check("gap_norv", 32'(rdVALID), 0);
    steps(1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rd_valid", 32'(rdVALID), 1);
      check("rd_data", 32'(rdDATA), 32'(exp_chr[i]));
      check("rd_mdf", 32'(mtMDF), 32'(exp_chr[i]));
      handshake();
      check("rd_pop", 32'(rdVALID), 0);
    end
    check("pre_eor", 32'(eor_cnt), 0);
    step();
    check("eor_pulse", 32'(mtEOR), 1);
    tick(2);
    check("eor_once", 32'(eor_cnt), 1);
    check("eor_idle", 32'(mtBUSY), 0);
    check("w1_ovr", 32'(mtOVR), 0);

    // 17 characters into a 16-deep buffer
    rdy_cnt = 0;
    go_pulse();
    wrVALID = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wrDATA = 9'(i + 9'h40);
      mc_step();
    end
    check("ov_rdy", 32'(rdy_cnt), 16);
    check("ov_cnt", 32'(mtFRMCNT), 16);
    check("ov_ovr", 32'(mtOVR), 1);
    wrVALID = 1'b0;
    @(negedge clk);
    mtMM = 1'b0;
    tick(1);
    check("mmw_busy", 32'(mtBUSY), 0);
    check("mmw_hold", {16'(mtOVR), mtFRMCNT}, {16'd1, 16'd16});

    // late read: rdREADY held low across a step
    @(negedge clk);
    mtMM = 1'b1;
    go_pulse();
    check("re_clr", {16'(mtOVR), mtFRMCNT}, 0);
    wrVALID = 1'b1;
    wrDATA = 9'h011; mc_step();
    wrDATA = 9'h022; mc_step();
    wrVALID = 1'b0;
    steps(9);
    step();
    check("late_v", 32'(rdVALID), 1);
    check("late_ovr0", 32'(mtOVR), 0);
    step();
    check("late_ovr", 32'(mtOVR), 1);
    check("late_dat", 32'(rdDATA), 32'h011);
    go_pulse();
    check("go_rd_ign", {16'(mtOVR), mtFRMCNT}, {16'd1, 16'd2});
    check("go_rd_busy", 32'(mtBUSY), 1);
    handshake();
    step();
    check("late_nxt", 32'(rdDATA), 32'h022);
    handshake();
    step();
    tick(2);
    check("late_eor", 32'(eor_cnt), 2);

    // NOP opcode: only BPICLK rising edges step
    mtMOP = 4'd0;
    wrp_mode = 1'b0;
    rdy_cnt = 0;
    go_pulse();
    wrVALID = 1'b1;
    wrDATA = 9'h0C3;
    mc_step();
    mc_step();
    check("nop_mc", 32'(rdy_cnt), 0);
    check("nop_mccnt", 32'(mtFRMCNT), 0);
    bpi_step();
    check("nop_bpi", 32'(rdy_cnt), 1);
    check("nop_mdf", 32'(mtMDF), 32'h0C3);
    @(negedge clk);
    rst = 1'b1;
    tick(1);
    check("rst_w_busy", 32'(mtBUSY), 0);
    check("rst_w_outs", {mtOVR, wrREADY, mtMDF, mtFRMCNT}, 0);
    @(negedge clk);
    rst = 1'b0;
    wrVALID = 1'b0;

    // MM dropped during GAP, then an empty record
    mtMOP = 4'd2;
    wrp_mode = 1'b1;
    go_pulse();
    wrVALID = 1'b1;
    wrDATA = 9'h1A5;
    mc_step();
    wrVALID = 1'b0;
    mc_step();
    steps(3);
    @(negedge clk);
    mtMM = 1'b0;
    tick(1);
    check("gap_drop", 32'(mtBUSY), 0);
    check("gap_rdv", 32'(rdVALID), 0);
    check("gap_cnt", 32'(mtFRMCNT), 1);
    tick(2);
    check("gap_noeor", 32'(eor_cnt), 2);
    @(negedge clk);
    mtMM = 1'b1;
    go_pulse();
    check("rs_clr", {16'(mtOVR), mtFRMCNT}, 0);
    mc_step();
    steps(8);
    step();
    check("emp_rdv", 32'(rdVALID), 0);
    tick(2);
    check("emp_eor", 32'(eor_cnt), 3);
    check("emp_idle", 32'(mtBUSY), 0);
    check("emp_cnt", 32'(mtFRMCNT), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
